// File: rtl/regfile_wr_sched_pkg.sv
// +--------------------------------------------------------------------+
// | regfile_wr_pkg : shared types, sizes and helpers for the scheduler |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package regfile_wr_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        INIT = 1'b1
    } state_t;

    localparam int NREG   = 8;
    localparam int RSEL_W = 3;
    localparam int DW     = 16;

    function automatic logic [NREG-1:0] onehot8(input logic [RSEL_W-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wr_sched_if.sv
// +--------------------------------------------------------------------+
// | regfile_wr_sched_if : write-back request bundle, one lane per src  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface regfile_wr_sched_if #(
    parameter int NREQ = 2,
    parameter int DW   = 16
);
    import regfile_wr_pkg::*;

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0][RSEL_W-1:0] req_dst;
    logic [NREQ-1:0][DW-1:0]     req_data;
    logic [NREQ-1:0]             req_ready;

    modport master (
        output req_valid,
        output req_dst,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dst,
        input  req_data,
        output req_ready
    );

endinterface

`default_nettype wire

// File: rtl/regfile_wr_sched_arb.sv
// +--------------------------------------------------------------------+
// | wr_rr_arbiter : 2-input write grant, round-robin when              |
// | REGFILE_WR_RR_EN is defined, else fixed priority to requester 0.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module wr_rr_arbiter (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] valid,
    input  wire logic       en,
    output logic      [1:0] grant
);

`ifdef REGFILE_WR_RR_EN
    logic r_last;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = r_last ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b0;
        end else if (|grant) begin
            r_last <= grant[1];
        end
    end
`else
    logic w_unused;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid[0]) begin
                grant = 2'b01;
            end else if (valid[1]) begin
                grant = 2'b10;
            end
        end
    end

    assign w_unused = ^{clk, rst_n};
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_wr_sched.sv
// +--------------------------------------------------------------------+
// | regfile_wr_sched : DR-staged write-port scheduler with init walk   |
// | and read-hazard reporting. Optional macro: REGFILE_WR_RR_EN.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module regfile_wr_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 16
) (
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    regfile_wr_sched_if.slave                   req,
    input  wire logic                           hold,
    input  wire logic                           init_start,
    input  wire logic [DW-1:0]                  init_data,
    output logic                                init_busy,
    output logic                                init_done,
    output logic                                DR_en,
    output logic      [DW-1:0]                  DR_in,
    output logic      [regfile_wr_pkg::NREG-1:0]   R_en,
    input  wire logic [regfile_wr_pkg::RSEL_W-1:0] rd_a_sel,
    input  wire logic [regfile_wr_pkg::RSEL_W-1:0] rd_b_sel,
    output logic      [regfile_wr_pkg::NREG-1:0]   pend_mask,
    output logic                                rd_hazard
);
    import regfile_wr_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RSEL_W-1:0]  r_cnt;
    logic               r_stg_valid;
    logic [RSEL_W-1:0]  r_stg_dst;
    logic               r_init_done;

    logic               w_arb_en;
    logic [NREQ-1:0]    w_grant;
    logic [RSEL_W-1:0]  w_load_dst;
    logic [NREG-1:0]    w_load_mask;

    assign w_arb_en = rst_n && (r_state == RUN) && !hold && !init_start;

    wr_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req.req_valid),
        .en    (w_arb_en),
        .grant (w_grant)
    );

    assign req.req_ready = w_grant;

    always_comb begin
        w_state_nxt = r_state;
        DR_en       = 1'b0;
        DR_in       = '0;
        w_load_dst  = '0;
        case (r_state)
            RUN: begin
                if (rst_n && init_start) begin
                    w_state_nxt = INIT;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (w_grant[i]) begin
                        DR_en      = 1'b1;
                        DR_in      = req.req_data[i];
                        w_load_dst = req.req_dst[i];
                    end
                end
            end
            INIT: begin
                DR_en      = rst_n;
                DR_in      = init_data;
                w_load_dst = r_cnt;
                if (r_cnt == RSEL_W'(NREG - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // The counter wraps from 7 to 0 on the final step, so RUN always sees 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_stg_valid <= 1'b0;
            r_stg_dst   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stg_valid <= DR_en;
            r_init_done <= (r_state == INIT) && (r_cnt == RSEL_W'(NREG - 1));
            if (r_state == INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (DR_en) begin
                r_stg_dst <= w_load_dst;
            end
        end
    end

    // Outputs are forced low while reset is held so a pending commit is dropped.
    assign R_en        = (rst_n && r_stg_valid) ? onehot8(r_stg_dst) : '0;
    assign init_busy   = rst_n && (r_state == INIT);
    assign init_done   = rst_n && r_init_done;
    assign w_load_mask = DR_en ? onehot8(w_load_dst) : '0;
    assign pend_mask   = R_en | w_load_mask;
    assign rd_hazard   = pend_mask[rd_a_sel] | pend_mask[rd_b_sel];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_sched.sv
// +--------------------------------------------------------------------+
// | tb_regfile_wr_sched : directed + random checks against a           |
// | countdown/queue style reference model of the write scheduler.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic        init_start;
    logic [15:0] init_data;
    logic        init_busy;
    logic        init_done;
    logic        DR_en;
    logic [15:0] DR_in;
    logic [7:0]  R_en;
    logic [2:0]  rd_a_sel;
    logic [2:0]  rd_b_sel;
    logic [7:0]  pend_mask;
    logic        rd_hazard;

    int checks = 0;
    int errors = 0;

    regfile_wr_sched_if #(.NREQ(2), .DW(16)) rif ();

    regfile_wr_sched #(.NREQ(2), .DW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (rif.slave),
        .hold       (hold),
        .init_start (init_start),
        .init_data  (init_data),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .DR_en      (DR_en),
        .DR_in      (DR_in),
        .R_en       (R_en),
        .rd_a_sel   (rd_a_sel),
        .rd_b_sel   (rd_b_sel),
        .pend_mask  (pend_mask),
        .rd_hazard  (rd_hazard)
    );

    always #5 clk = ~clk;

    // Reference model: init is a countdown of remaining loads, the staged write
    // is a single pending commit record, and the file is a plain array.
    int          m_init_left = 0;
    bit          m_commit_v  = 0;
    int          m_commit_dst = 0;
    logic [15:0] m_commit_data = '0;
    bit          m_done = 0;
    bit          m_last = 0;
    logic [15:0] exp_rf [8];
    logic [15:0] emu_rf [8];
    logic [15:0] emu_dr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        rif.req_valid = 2'b00;
        rif.req_dst   = '0;
        rif.req_data  = '0;
        hold          = 1'b0;
        init_start    = 1'b0;
        rd_a_sel      = 3'd0;
        rd_b_sel      = 3'd0;
    endtask

    task automatic cyc();
        bit          ld;
        int          ldst;
        int          w;
        logic [15:0] ldat;
        logic [1:0]  rdy;
        logic [7:0]  exp_ren;
        logic [7:0]  exp_pend;
        logic [7:0]  o_ren;
        logic        o_dren;
        logic [15:0] o_drin;
        #1;
        rdy = 2'b00; ld = 0; ldst = 0; ldat = '0; w = 0;
        if (rst_n) begin
            if (m_init_left > 0) begin
                ld = 1; ldst = 8 - m_init_left; ldat = init_data;
            end else if (!hold && !init_start && rif.req_valid != 2'b00) begin
`ifdef REGFILE_WR_RR_EN
                if (rif.req_valid == 2'b11) w = m_last ? 0 : 1;
                else                        w = rif.req_valid[1] ? 1 : 0;
`else
                w = rif.req_valid[0] ? 0 : 1;
`endif
                rdy[w] = 1'b1;
                ld     = 1;
                ldst   = int'(rif.req_dst[w]);
                ldat   = rif.req_data[w];
            end
        end
        exp_ren  = (rst_n && m_commit_v) ? (8'b1 << m_commit_dst) : 8'h00;
        exp_pend = exp_ren | (ld ? (8'b1 << ldst) : 8'h00);

        chk("req_ready", 32'(rif.req_ready), 32'(rdy));
        chk("DR_en", 32'(DR_en), 32'(ld));
        if (ld) chk("DR_in", 32'(DR_in), 32'(ldat));
        chk("R_en", 32'(R_en), 32'(exp_ren));
        chk("pend_mask", 32'(pend_mask), 32'(exp_pend));
        chk("rd_hazard", 32'(rd_hazard), 32'(exp_pend[rd_a_sel] | exp_pend[rd_b_sel]));
        chk("init_busy", 32'(init_busy), 32'(rst_n && m_init_left > 0));
        chk("init_done", 32'(init_done), 32'(rst_n && m_done));

        o_ren = R_en; o_dren = DR_en; o_drin = DR_in;
        @(posedge clk);
        for (int i = 0; i < 8; i++) if (o_ren[i]) emu_rf[i] = emu_dr;
        if (o_dren) emu_dr = o_drin;

        if (!rst_n) begin
            m_init_left = 0; m_commit_v = 0; m_done = 0; m_last = 0;
        end else begin
            if (m_commit_v) exp_rf[m_commit_dst] = m_commit_data;
            m_done        = (m_init_left == 1);
            m_commit_v    = ld;
            m_commit_dst  = ldst;
            m_commit_data = ldat;
            if (m_init_left > 0)  m_init_left--;
            else if (init_start)  m_init_left = 8;
            if (rdy != 2'b00)     m_last = rdy[1];
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin exp_rf[i] = '0; emu_rf[i] = '0; end
        set_idle();
        init_data = '0;
        rst_n = 1'b0;
        @(negedge clk);
        cyc(); cyc();
        rst_n = 1'b1;

        // single write to R3
        rif.req_valid = 2'b01; rif.req_dst[0] = 3'd3; rif.req_data[0] = 16'hA5A5; rd_a_sel = 3'd3;
        cyc();
        rif.req_valid = 2'b00;
        cyc(); cyc();

        // contention, destinations 1 and 2
        rif.req_valid = 2'b11;
        rif.req_dst[0] = 3'd1; rif.req_data[0] = 16'h1111;
        rif.req_dst[1] = 3'd2; rif.req_data[1] = 16'h2222;
        repeat (4) cyc();
        rif.req_valid = 2'b00;
        cyc(); cyc();

        // init with a requester held valid throughout
        init_data = 16'h1234; init_start = 1'b1;
        rif.req_valid = 2'b01; rif.req_dst[0] = 3'd4; rif.req_data[0] = 16'h4444;
        cyc();
        init_start = 1'b0;
        repeat (10) cyc();
        rif.req_valid = 2'b00;
        cyc();

        // hold raised the cycle after a grant to R5
        rif.req_valid = 2'b01; rif.req_dst[0] = 3'd5; rif.req_data[0] = 16'h5555;
        cyc();
        hold = 1'b1;
        repeat (3) cyc();
        hold = 1'b0; rif.req_valid = 2'b00;
        cyc();

        // reset in the middle of init, then a write to R0
        init_data = 16'hCAFE; init_start = 1'b1;
        cyc();
        init_start = 1'b0;
        repeat (4) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        rif.req_valid = 2'b01; rif.req_dst[0] = 3'd0; rif.req_data[0] = 16'hBEEF;
        cyc();
        rif.req_valid = 2'b00;
        cyc(); cyc();

        // back-to-back writes to R7, last one wins
        rd_a_sel = 3'd7;
        rif.req_valid = 2'b01; rif.req_dst[0] = 3'd7; rif.req_data[0] = 16'h0001;
        cyc();
        rif.req_data[0] = 16'h0002;
        cyc();
        rif.req_valid = 2'b00;
        repeat (3) cyc();

        // randomized traffic
        repeat (600) begin
            rst_n         = ($urandom_range(99, 0) >= 2);
            hold          = ($urandom_range(99, 0) < 20);
            init_start    = ($urandom_range(99, 0) < 3);
            init_data     = 16'($urandom);
            rif.req_valid = 2'($urandom);
            rif.req_dst[0]  = 3'($urandom); rif.req_data[0] = 16'($urandom);
            rif.req_dst[1]  = 3'($urandom); rif.req_data[1] = 16'($urandom);
            rd_a_sel      = 3'($urandom);
            rd_b_sel      = 3'($urandom);
            cyc();
        end

        set_idle();
        rst_n = 1'b1;
        repeat (12) cyc();

        for (int i = 0; i < 8; i++) chk($sformatf("rf[%0d]", i), 32'(emu_rf[i]), 32'(exp_rf[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
